// File: rtl/image_pattern_gen_pkg.sv
// Shared definitions for the synthetic image sensor.
//   PIX_W      : pixel data width
//   CNT_W      : width of the col/row/blanking/frame counters
//   S_*        : timing FSM state encodings
//   PAT_*      : test pattern select encodings (mode input)
package image_pattern_gen_pkg;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VBLANK = 3'd1;
  localparam logic [2:0] S_LEAD   = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_TRAIL  = 3'd5;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_DIAG  = 2'd3;

endpackage

// File: rtl/image_pattern_pix.sv
// Combinational test-pattern function.
//   mode : pattern select (PAT_*)
//   col  : column index, low PIX_W bits
//   row  : row index, low PIX_W bits
//   fc   : completed-frame count, low PIX_W bits
//   pix  : pattern value for this (col, row, frame)
// Only the low PIX_W bits of the indices reach this block: every pattern is
// truncated to PIX_W bits, and a modulo-2^PIX_W sum only depends on them.
module image_pattern_pix
  import image_pattern_gen_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] col,
  input  logic [PIX_W-1:0] row,
  input  logic [PIX_W-1:0] fc,
  output logic [PIX_W-1:0] pix
);

  always_comb begin
    pix = '0;
    case (mode)
      PAT_HRAMP: pix = col;
      PAT_VRAMP: pix = row;
      PAT_CHECK: pix = (col[3] ^ row[3]) ? '1 : '0;
      PAT_DIAG:  pix = col + row + fc;
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/image_pattern_gen.sv
// Synthetic image sensor: drives frame/line valid and 12-bit test-pattern
// pixel data with deterministic timing.
//   clk         : pixel clock
//   reset_n     : asynchronous active-low reset
//   enable      : 1 = generate frames continuously
//   mode        : pattern select, latched at each frame start
//   pix_fv      : frame valid
//   pix_lv      : line valid
//   pix_data    : pixel value, 0 whenever pix_lv is low
//   frame_start : one-cycle pulse on the cycle pix_fv rises
//   frame_count : completed frames, wraps at 0xFFFF
module image_pattern_gen
  import image_pattern_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BLANK  = 32,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic             pix_fv,
  output logic             pix_lv,
  output logic [PIX_W-1:0] pix_data,
  output logic             frame_start,
  output logic [CNT_W-1:0] frame_count
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] col_q,   col_d;
  logic [CNT_W-1:0] row_q,   row_d;
  logic [CNT_W-1:0] fc_q,    fc_d;
  logic [1:0]       mode_q,  mode_d;
  logic             fv_q,    fv_d;
  logic             lv_q,    lv_d;
  logic             fs_q,    fs_d;
  logic [PIX_W-1:0] data_q,  data_d;
  logic [PIX_W-1:0] pat_pix;

  // Timing FSM. cnt_q counts cycles spent in the blanking/lead/trail states;
  // col_q is the in-line counter while in S_LINE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    fc_d    = fc_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_VBLANK;
          cnt_d   = '0;
        end
      end
      S_VBLANK: begin
        if (cnt_q == CNT_W'(V_BLANK - 1)) begin
          state_d = S_LEAD;
          cnt_d   = '0;
          mode_d  = mode;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LEAD: begin
        if (cnt_q == CNT_W'(FV_LEAD - 1)) begin
          state_d = S_LINE;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LINE: begin
        if (col_q == CNT_W'(H_ACTIVE - 1)) begin
          cnt_d   = '0;
          state_d = (row_q < CNT_W'(V_ACTIVE - 1)) ? S_HBLANK : S_TRAIL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          state_d = S_LINE;
          row_d   = row_q + 1'b1;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == CNT_W'(FV_TRAIL - 1)) begin
          fc_d    = fc_q + 1'b1;
          cnt_d   = '0;
          state_d = enable ? S_VBLANK : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered bus
  // lines up with the state register on the same cycle.
  always_comb begin
    fv_d   = (state_d == S_LEAD) || (state_d == S_LINE) ||
             (state_d == S_HBLANK) || (state_d == S_TRAIL);
    lv_d   = (state_d == S_LINE);
    fs_d   = (state_d == S_LEAD) && (state_q == S_VBLANK);
    data_d = lv_d ? pat_pix : '0;
  end

  image_pattern_pix u_pix (
    .mode (mode_d),
    .col  (col_d[PIX_W-1:0]),
    .row  (row_d[PIX_W-1:0]),
    .fc   (fc_d[PIX_W-1:0]),
    .pix  (pat_pix)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fc_q    <= '0;
      mode_q  <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      fs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fc_q    <= fc_d;
      mode_q  <= mode_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      fs_q    <= fs_d;
      data_q  <= data_d;
    end
  end

  assign pix_fv      = fv_q;
  assign pix_lv      = lv_q;
  assign pix_data    = data_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
